blockade_loader: RTL and testbench

BLOCKADE_LOADER -- requirements
Module: blockade_loader

---
 rtl/blockade_loader.sv | 183 ++++++++++++++++++
 tb/tb_blockade_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockade_loader.sv
// Blockade ROM/DIP download loader.
// Takes the host's byte stream, routes ROM-image bytes to the program or
// graphics ROM with a multi-cycle write strobe, latches the DIP block, and
// holds the game core in reset until a complete image has been loaded.
module blockade_loader #(
    parameter int PROG_BYTES  = 4096,
    parameter int GFX_BYTES   = 1024,
    parameter int WR_CYCLES   = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr_prog,
    output logic        dn_wr_gfx,
    output logic [7:0]  dip_sw0,
    output logic [7:0]  dip_sw1,
    output logic        game_reset,
    output logic        rom_ok
);

    localparam logic [7:0]  IDX_ROM   = 8'd0;
    localparam logic [7:0]  IDX_DIP   = 8'd254;
    localparam int          TOTAL     = PROG_BYTES + GFX_BYTES;
    localparam logic [24:0] PROG_END  = 25'(PROG_BYTES);
    localparam logic [24:0] ROM_END   = 25'(TOTAL);
    localparam logic [13:0] ROM_TOTAL = 14'(TOTAL);
    localparam logic [13:0] GFX_BASE  = 14'(PROG_BYTES);
    localparam logic [3:0]  WR_LAST   = 4'(WR_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_HOLD,
        S_READY
    } state_t;

    state_t      state;
    logic        armed;      // set one clock after reset release; gates leaving IDLE
    logic [3:0]  wr_cnt;     // clocks the current strobe has been held
    logic [7:0]  hold_cnt;   // clocks spent in HOLD
    logic [13:0] byte_cnt;   // accepted in-region ROM bytes, saturating
    logic        dl_ended;   // download ended while a write was still in flight

    // Input decode shared by the FSM and the DIP latch.
    logic        rom_dl;
    logic        in_prog;
    logic        in_gfx;
    logic [13:0] gfx_off;
    logic [13:0] cnt_next;

    assign rom_dl   = ioctl_download && (ioctl_index == IDX_ROM);
    assign in_prog  = (ioctl_addr < PROG_END);
    assign in_gfx   = !in_prog && (ioctl_addr < ROM_END);
    // Region addresses never exceed 14 bits, so the low bits carry the offset.
    assign gfx_off  = ioctl_addr[13:0] - GFX_BASE;
    assign cnt_next = (byte_cnt == ROM_TOTAL) ? byte_cnt : byte_cnt + 14'd1;

    // Loader FSM with all of its registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block samples pre-edge values and ordering is irrelevant.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            wr_cnt     <= '0;
            hold_cnt   <= '0;
            byte_cnt   <= '0;
            dl_ended   <= 1'b0;
            ioctl_wait <= 1'b0;
            dn_addr    <= '0;
            dn_data    <= '0;
            dn_wr_prog <= 1'b0;
            dn_wr_gfx  <= 1'b0;
            game_reset <= 1'b1;
            rom_ok     <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (armed && rom_dl) begin
                        state    <= S_LOAD;
                        byte_cnt <= '0;
                        rom_ok   <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (!rom_dl) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                        rom_ok   <= (byte_cnt == ROM_TOTAL);
                    end else if (ioctl_wr && (in_prog || in_gfx)) begin
                        // Out-of-region bytes fall through here and are dropped.
                        state      <= S_WRITE;
                        dn_addr    <= in_prog ? ioctl_addr[13:0] : gfx_off;
                        dn_data    <= ioctl_dout;
                        dn_wr_prog <= in_prog;
                        dn_wr_gfx  <= in_gfx;
                        ioctl_wait <= 1'b1;
                        wr_cnt     <= '0;
                        dl_ended   <= 1'b0;
                        byte_cnt   <= cnt_next;
                    end
                end

                S_WRITE: begin
                    // Address, data and strobe are frozen here; stray ioctl_wr
                    // pulses from the host are simply not looked at.
                    if (!rom_dl) begin
                        dl_ended <= 1'b1;
                    end
                    if (wr_cnt == WR_LAST) begin
                        dn_wr_prog <= 1'b0;
                        dn_wr_gfx  <= 1'b0;
                        ioctl_wait <= 1'b0;
                        if (dl_ended || !rom_dl) begin
                            state    <= S_HOLD;
                            hold_cnt <= '0;
                            rom_ok   <= (byte_cnt == ROM_TOTAL);
                        end else begin
                            state <= S_LOAD;
                        end
                    end else begin
                        wr_cnt <= wr_cnt + 4'd1;
                    end
                end

                S_HOLD: begin
                    if (rom_dl) begin
                        state    <= S_LOAD;
                        byte_cnt <= '0;
                        rom_ok   <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= rom_ok ? S_READY : S_IDLE;
                        game_reset <= !rom_ok;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                S_READY: begin
                    if (rom_dl) begin
                        state      <= S_LOAD;
                        byte_cnt   <= '0;
                        rom_ok     <= 1'b0;
                        game_reset <= 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    game_reset <= 1'b1;
                end
            endcase
        end
    end

    // DIP block latch; independent of the FSM so it works in every state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dip_sw0 <= '0;
            dip_sw1 <= '0;
        end else if (ioctl_wr && (ioctl_index == IDX_DIP)) begin
            if (ioctl_addr == 25'd0) begin
                dip_sw0 <= ioctl_dout;
            end
            if (ioctl_addr == 25'd1) begin
                dip_sw1 <= ioctl_dout;
            end
        end
    end

endmodule

// File: tb/tb_blockade_loader.sv
// Self-checking bench for blockade_loader: random byte data and gaps, a
// queue of expected ROM writes filled by the stimulus side, and an
// independent monitor that pops and compares every strobe the DUT issues.
module tb_blockade_loader;

    localparam int PROG  = 4096;
    localparam int GFX   = 1024;
    localparam int WRC   = 2;
    localparam int HOLDC = 16;
    localparam int TOTAL = PROG + GFX;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr_prog;
    logic        dn_wr_gfx;
    logic [7:0]  dip_sw0;
    logic [7:0]  dip_sw1;
    logic        game_reset;
    logic        rom_ok;

    blockade_loader #(
        .PROG_BYTES (PROG),
        .GFX_BYTES  (GFX),
        .WR_CYCLES  (WRC),
        .HOLD_CYCLES(HOLDC)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_index   (ioctl_index),
        .ioctl_wait    (ioctl_wait),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_wr_prog    (dn_wr_prog),
        .dn_wr_gfx     (dn_wr_gfx),
        .dip_sw0       (dip_sw0),
        .dip_sw1       (dip_sw1),
        .game_reset    (game_reset),
        .rom_ok        (rom_ok)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          gfx;
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state.
    bit         rom_active = 1'b0;
    int         accepted   = 0;
    int         exp_prog   = 0;
    int         exp_gfx    = 0;
    logic [7:0] dip0_m     = '0;
    logic [7:0] dip1_m     = '0;

    // Monitor observations.
    int prog_pulses = 0;
    int gfx_pulses  = 0;
    int wait_seen   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Reference: where a ROM-image byte should land, straight from the memory map.
    task automatic model_rom_byte(input int addr, input logic [7:0] data);
        wr_t w;
        if (addr < PROG) begin
            w.gfx = 1'b0; w.addr = 14'(addr); w.data = data;
            exp_q.push_back(w);
            exp_prog++;
            accepted++;
        end else if (addr < TOTAL) begin
            w.gfx = 1'b1; w.addr = 14'(addr - PROG); w.data = data;
            exp_q.push_back(w);
            exp_gfx++;
            accepted++;
        end
    endtask

    task automatic clear_counts();
        prog_pulses = 0; gfx_pulses = 0; wait_seen = 0;
        exp_prog = 0; exp_gfx = 0;
    endtask

    task automatic start_download(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        rom_active     = (idx == 8'd0);
        if (rom_active) accepted = 0;
        tick(3);
    endtask

    // Host side: honours ioctl_wait (bounded), pulses ioctl_wr for one clock.
    task automatic send_byte(input int addr, input logic [7:0] data, input int gap);
        int n = 0;
        while (ioctl_wait === 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        if (n == 50) check("ioctl_wait release", ioctl_wait, 0);
        ioctl_addr = 25'(addr);
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        if (rom_active) model_rom_byte(addr, data);
        if (ioctl_index == 8'd254 && addr == 0) dip0_m = data;
        if (ioctl_index == 8'd254 && addr == 1) dip1_m = data;
        tick(1);
        ioctl_wr = 1'b0;
        tick(gap - 1);
    endtask

    task automatic check_load_counts(input string tag);
        check({tag, " prog pulses"}, prog_pulses, exp_prog);
        check({tag, " gfx pulses"}, gfx_pulses, exp_gfx);
        check({tag, " queue drained"}, exp_q.size(), 0);
    endtask

    // Monitor: pairs each strobe with the oldest expected write, checks width and stability.
    bit          in_pulse = 1'b0;
    int          width    = 0;
    logic [13:0] p_addr;
    logic [7:0]  p_data;
    wr_t         e;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            in_pulse = 1'b0;
        end else begin
            if (ioctl_wait) wait_seen++;
            if ((dn_wr_prog || dn_wr_gfx) && !in_pulse) begin
                in_pulse = 1'b1;
                width    = 1;
                p_addr   = dn_addr;
                p_data   = dn_data;
                check("single strobe", dn_wr_prog & dn_wr_gfx, 0);
                check("wait with strobe", ioctl_wait, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected strobe: gfx=%0d addr=0x%0h data=0x%0h, none expected",
                             dn_wr_gfx, dn_addr, dn_data);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe target", dn_wr_gfx, e.gfx);
                    check("dn_addr", dn_addr, e.addr);
                    check("dn_data", dn_data, e.data);
                end
                if (dn_wr_gfx) gfx_pulses++;
                else prog_pulses++;
            end else if ((dn_wr_prog || dn_wr_gfx) && in_pulse) begin
                width++;
                check("dn_addr stable", dn_addr, p_addr);
                check("dn_data stable", dn_data, p_data);
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                check("strobe width", width, WRC);
                check("wait drops with strobe", ioctl_wait, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lows;

        // Reset values.
        reset_n = 1'b0;
        tick(3);
        @(negedge clk_sys);
        check("rst game_reset", game_reset, 1);
        check("rst ioctl_wait", ioctl_wait, 0);
        check("rst dn_wr_prog", dn_wr_prog, 0);
        check("rst dn_wr_gfx", dn_wr_gfx, 0);
        check("rst rom_ok", rom_ok, 0);
        check("rst dn_addr", dn_addr, 0);
        check("rst dn_data", dn_data, 0);
        check("rst dip_sw0", dip_sw0, 0);
        check("rst dip_sw1", dip_sw1, 0);
        tick(1);
        reset_n = 1'b1;
        tick(2);

        // Full image, then restart while in HOLD.
        clear_counts();
        start_download(8'd0);
        for (int a = 0; a < TOTAL; a++) send_byte(a, 8'($urandom), 4);
        check_load_counts("load A");
        ioctl_download = 1'b0;
        rom_active     = 1'b0;
        tick(4);
        check("load A rom_ok in HOLD", rom_ok, (accepted >= TOTAL) ? 1 : 0);
        check("load A game_reset in HOLD", game_reset, 1);
        clear_counts();
        start_download(8'd0);
        @(negedge clk_sys);
        check("restart rom_ok cleared", rom_ok, 0);
        check("restart game_reset", game_reset, 1);
        tick(1);

        // Restarted load resumes from 0; reset lands mid-write of 0x123.
        for (int a = 0; a < 'h123; a++) send_byte(a, 8'($urandom), 4);
        send_byte('h123, 8'($urandom), 1);
        @(negedge clk_sys);
        check("strobe up before reset", dn_wr_prog, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async drop dn_wr_prog", dn_wr_prog, 0);
        check("async drop ioctl_wait", ioctl_wait, 0);
        check("async game_reset", game_reset, 1);
        check("restart prog pulses", prog_pulses, exp_prog);
        check("restart queue drained", exp_q.size(), 0);
        ioctl_download = 1'b0;
        rom_active     = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        @(negedge clk_sys);
        check("post-reset rom_ok", rom_ok, 0);
        check("post-reset game_reset", game_reset, 1);
        tick(1);

        // Fresh full image; measure game_reset release.
        clear_counts();
        start_download(8'd0);
        for (int a = 0; a < TOTAL; a++) send_byte(a, 8'($urandom), 4);
        check_load_counts("load B");
        ioctl_download = 1'b0;
        rom_active     = 1'b0;
        n = 0;
        while (game_reset === 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        check("game_reset fall delay", n, HOLDC + 1);
        check("load B rom_ok", rom_ok, (accepted >= TOTAL) ? 1 : 0);

        // DIP writes in READY.
        clear_counts();
        start_download(8'd254);
        for (int i = 0; i < 6; i++) begin
            send_byte($urandom_range(0, 3), 8'($urandom), 2);
            @(negedge clk_sys);
            check("dip_sw0 random", dip_sw0, dip0_m);
            check("dip_sw1 random", dip_sw1, dip1_m);
            tick(1);
        end
        send_byte(0, 8'h03, 2);
        send_byte(1, 8'hA5, 2);
        send_byte(2, 8'hFF, 2);
        @(negedge clk_sys);
        check("dip_sw0", dip_sw0, dip0_m);
        check("dip_sw1", dip_sw1, dip1_m);
        check("dip game_reset", game_reset, 0);
        check("dip rom_ok", rom_ok, 1);
        check("dip no wait", wait_seen, 0);
        tick(1);
        ioctl_download = 1'b0;
        tick(2);

        // Foreign index is ignored.
        start_download(8'd7);
        for (int i = 0; i < 16; i++) send_byte($urandom_range(0, TOTAL - 1), 8'($urandom), 2);
        ioctl_download = 1'b0;
        tick(4);
        check("idx7 strobes", prog_pulses + gfx_pulses, 0);
        check("idx7 no wait", wait_seen, 0);
        check("idx7 game_reset", game_reset, 0);

        // Out-of-region bytes only.
        start_download(8'd0);
        clear_counts();
        for (int a = 'h1400; a < 'h1500; a++) send_byte(a, 8'($urandom), $urandom_range(1, 3));
        ioctl_download = 1'b0;
        rom_active     = 1'b0;
        tick(30);
        check("oor strobes", prog_pulses + gfx_pulses, exp_prog + exp_gfx);
        check("oor no wait", wait_seen, 0);
        check("oor queue", exp_q.size(), 0);
        check("oor rom_ok", rom_ok, (accepted >= TOTAL) ? 1 : 0);
        check("oor game_reset", game_reset, 1);

        // Short image.
        clear_counts();
        start_download(8'd0);
        for (int a = 0; a < 4000; a++) send_byte(a, 8'($urandom), $urandom_range(3, 5));
        check_load_counts("short");
        ioctl_download = 1'b0;
        rom_active     = 1'b0;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (game_reset !== 1'b1) lows++;
        end
        check("short game_reset lows", lows, 0);
        check("short rom_ok", rom_ok, (accepted >= TOTAL) ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
